// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - streams {address, data} pairs from a register file read port
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] end_r;
    logic [ADDR_W-1:0] cur_inc;
    logic              beat_taken;

    assign beat_taken = out_valid & out_ready;
    // Explicit wrap so a non power-of-two NUM_REGS still walks 0..NUM_REGS-1
    assign cur_inc    = (cur == ADDR_W'(NUM_REGS - 1)) ? '0 : cur + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = READ;
            READ: state_nxt = SEND;
            SEND: begin
                if (beat_taken) begin
                    state_nxt = out_last ? FIN : READ;
                end
            end
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rf_addr = '0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                rf_addr = '0;
            end
            READ, SEND: begin
                rf_addr = cur;
                busy    = 1'b1;
            end
            FIN: begin
                rf_addr = cur;
                busy    = 1'b1;
                done    = 1'b1;
            end
            default: begin
                rf_addr = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur       <= '0;
            end_r     <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur   <= first_addr;
                        end_r <= last_addr;
                    end
                end
                READ: begin
                    out_data  <= rf_data;
                    out_addr  <= cur;
                    out_last  <= (cur == end_r);
                    out_valid <= 1'b1;
                end
                SEND: begin
                    if (beat_taken) begin
                        out_valid <= 1'b0;
                        if (!out_last) begin
                            cur <= cur_inc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Debug-side reader for the 32x32 register file. On a start pulse it walks a register address range through one spare combinational read port and streams each {address, data} pair out on a valid/ready interface, for a debug UART or trace buffer. The block never writes the register file; it is purely a consumer of its read port.

Parameters:
NUM_REGS, 32, number of registers in the file; the address wraps modulo NUM_REGS.
ADDR_W, 5, register address width; equals log2(NUM_REGS).
DATA_W, 32, register data width.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset, sampled on rising clk.
start  input  1  one-cycle request to begin a dump; ignored while busy=1.
first_addr  input  ADDR_W  first register to dump; sampled when start is accepted.
last_addr  input  ADDR_W  final register to dump, inclusive; sampled when start is accepted.
rf_addr  output  ADDR_W  address driven to the register file read port.
rf_data  input  DATA_W  combinational read data returned for rf_addr.
out_valid  output  1  out_* fields hold a valid beat.
out_ready  input  1  downstream accepts the beat.
out_addr  output  ADDR_W  register index of the current beat.
out_data  output  DATA_W  register contents of the current beat.
out_last  output  1  current beat is the final one of the dump.
busy  output  1  a dump is in progress (state != IDLE).
done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE. rf_addr=0, out_valid=0, out_addr=0, out_data=0, out_last=0, busy=0, done=0. Reset mid-dump aborts the dump immediately. No partial beat and no done pulse follow an abort.
- The FSM has four states: IDLE, READ, SEND, FIN.
- IDLE: if start=1, latch first_addr into cur and last_addr into end_r, then go to READ. busy=0.
- READ (1 cycle): rf_addr=cur. At the clock edge, register rf_data into out_data, cur into out_addr, and (cur==end_r) into out_last. Set out_valid=1 and go to SEND.
- SEND: hold all out_* fields stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready, clear out_valid.
  - If out_last=1, go to FIN.
  - Otherwise set cur = (cur+1) mod NUM_REGS and go to READ.
- FIN (1 cycle): done=1, then go to IDLE. busy deasserts in the cycle after FIN.
- rf_addr holds cur in every non-IDLE state and 0 in IDLE.
- Latency: start sampled at edge E0 gives out_valid=1 after edge E1. Maximum throughput is one beat per 2 cycles.
- Wrap-around: if first_addr > last_addr, the sequence wraps through NUM_REGS-1 to 0. Beat count = ((last-first) mod NUM_REGS) + 1.
- first_addr == last_addr produces exactly one beat with out_last=1.
- first=0, last=31 dumps all 32 registers. Register 0 reads as whatever the file returns (0 on a correct file); it is not special-cased.
- Each word is sampled in its own READ cycle, so the dump is not an atomic snapshot. A write to register k committed before k's READ edge is visible in the dump; a later write is not.
- start while busy=1 is ignored. It is not queued and does not alter first/last.
- start coincident with rst_n=0: reset wins.
- out_ready asserted with out_valid=0 has no effect.

Test Plan:
- Full dump: preload regs[i]=32'hA000_0000+i, start with first=0, last=31, out_ready=1 → 32 beats with out_addr 0..31 and data A000_0000..A000_001F (reg0 reads 0), out_last only on addr 31, done one cycle later, 66 cycles from start to done.
- Backpressure: first=3, last=5, out_ready toggling 0,0,1 → each beat is held stable for 3 cycles. Beats are (3,d3), (4,d4), (5,d5) with no duplicates or drops.
- Wrap: first=30, last=1 → beats appear in the order 30, 31, 0, 1. out_last=1 only on addr 1.
- Single and ignored start: first=last=7 gives one beat (7, d7) with out_last=1. A second start pulsed during SEND (first=0) is ignored, and no extra beats appear.
- Reset mid-dump: start 0..31, assert rst_n=0 for one cycle during beat 10's SEND → next cycle out_valid=0, busy=0, rf_addr=0, with no done pulse. A fresh start=0..2 then yields 3 correct beats.
- Live write: dump 8..9 while the processor writes reg9=32'hDEAD_BEEF in the cycle before reg9's READ → beat 9 carries DEAD_BEEF.
